// File: rtl/reflet_bus_arbiter.sv
// reflet_bus_arbiter: two masters onto one memory port, master 0 priority.
// Optional REFLET_ARB_STARVATION_GUARD_EN bounds master 1's wait to `burst` grants.
module reflet_bus_arbiter #(
    parameter int wordsize = 16,
    parameter int addrSize = 16,
    parameter int burst    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [addrSize-1:0] m0_addr,
    input  logic [wordsize-1:0] m0_data_out,
    input  logic                m0_write_en,
    output logic [wordsize-1:0] m0_data_in,
    output logic                m0_ack,
    input  logic                m1_req,
    input  logic [addrSize-1:0] m1_addr,
    input  logic [wordsize-1:0] m1_data_out,
    input  logic                m1_write_en,
    output logic [wordsize-1:0] m1_data_in,
    output logic                m1_ack,
    output logic                mem_enable,
    output logic [addrSize-1:0] mem_addr,
    output logic [wordsize-1:0] mem_data_out,
    output logic                mem_write_en,
    input  logic [wordsize-1:0] mem_data_in
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t state;
    logic   gnt;
    logic   any_req;
    logic   win1;
    logic   take;

`ifdef REFLET_ARB_STARVATION_GUARD_EN
    localparam int CW = $clog2(burst) + 1;
    localparam logic [CW-1:0] BURST_C = CW'(burst);

    logic [CW-1:0] cnt;

    assign win1 = m1_req && ((cnt == BURST_C) || !m0_req);
`else
    assign win1 = m1_req && !m0_req;
`endif

    assign any_req = m0_req | m1_req;

    // The master being acked cannot win again straight away; it goes via IDLE.
    always_comb begin
        take = 1'b0;
        unique case (state)
            IDLE:    take = any_req;
            ACK:     take = any_req && (win1 != gnt);
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            mem_enable   <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_write_en <= 1'b0;
        end else begin
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            mem_enable   <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_write_en <= 1'b0;
            unique case (state)
                IDLE, ACK: begin
                    if (take) begin
                        state        <= ISSUE;
                        gnt          <= win1;
                        mem_enable   <= 1'b1;
                        mem_addr     <= win1 ? m1_addr : m0_addr;
                        mem_data_out <= win1 ? m1_data_out : m0_data_out;
                        mem_write_en <= win1 ? m1_write_en : m0_write_en;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state  <= ACK;
                    m0_ack <= !gnt;
                    m1_ack <= gnt;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REFLET_ARB_STARVATION_GUARD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (take) begin
            if (win1 || !m1_req)
                cnt <= '0;
            else if (cnt != BURST_C)
                cnt <= cnt + 1'b1;
        end
    end
`endif

    // Read data passes straight through, gated so idle outputs stay zero.
    assign m0_data_in = m0_ack ? mem_data_in : '0;
    assign m1_data_in = m1_ack ? mem_data_in : '0;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Bench for reflet_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model.
module tb_reflet_bus_arbiter;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_data_out = '0, m1_data_out = '0;
    logic        m0_write_en = 1'b0, m1_write_en = 1'b0;
    logic [15:0] m0_data_in, m1_data_in;
    logic        m0_ack, m1_ack;
    logic        mem_enable, mem_write_en;
    logic [15:0] mem_addr, mem_data_out, mem_data_in;

    int checks = 0;
    int errors = 0;

    logic [15:0] tb_mem [256];
    logic [15:0] mdl_mem [256];
    logic [15:0] rdata = '0;
    logic        mem_init = 1'b0;

    reflet_bus_arbiter #(.wordsize(16), .addrSize(16), .burst(BURST)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_data_out(m0_data_out),
        .m0_write_en(m0_write_en), .m0_data_in(m0_data_in), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_data_out(m1_data_out),
        .m1_write_en(m1_write_en), .m1_data_in(m1_data_in), .m1_ack(m1_ack),
        .mem_enable(mem_enable), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_write_en(mem_write_en),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [7:0] i);
        return (i == 8'h10) ? 16'h1234 : {i, ~i};
    endfunction

    // Memory with registered one-cycle read, read-before-write.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= pat(8'(i));
        end else if (mem_enable) begin
            rdata <= tb_mem[mem_addr[7:0]];
            if (mem_write_en) tb_mem[mem_addr[7:0]] <= mem_data_out;
        end
    end
    assign mem_data_in = rdata;

    function automatic logic [67:0] outs();
        return {mem_enable, mem_write_en, mem_addr, mem_data_out,
                m0_ack, m1_ack, m0_data_in, m1_data_in};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0; m0_write_en = 0; m1_write_en = 0;
        m0_addr = '0; m1_addr = '0; m0_data_out = '0; m1_data_out = '0;
    endtask

    task automatic do_reset();
        reset = 1; clear_inputs();
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs(); mem_init = 1;
        tick(); mem_init = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs() !== '0) begin
                errors++;
                $display("FAIL reset_hold: outputs %h, required 0", outs());
            end
        end
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (outs() !== '0) begin
                errors++;
                $display("FAIL reset_idle: outputs %h, required 0", outs());
            end
        end
    endtask

    task automatic test_m0_read();
        do_reset();
        m0_req = 1; m0_addr = 16'h8010; m0_write_en = 0;
        tick();
        checks++;
        if ({mem_enable, mem_write_en, mem_addr} !== {2'b10, 16'h8010}) begin
            errors++;
            $display("FAIL read_issue: en/we/addr %b %b %h, required 1 0 8010",
                     mem_enable, mem_write_en, mem_addr);
        end
        checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            errors++;
            $display("FAIL read_issue_ack: acks %b, required 00", {m0_ack, m1_ack});
        end
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m0_data_in !== 16'h1234) begin
            errors++;
            $display("FAIL read_ack: ack %b data %h, required 1 1234", m0_ack, m0_data_in);
        end
        checks++;
        if ({m1_ack, m1_data_in, mem_enable} !== '0) begin
            errors++;
            $display("FAIL read_ack_other: m1_ack %b m1_data %h en %b, required 0",
                     m1_ack, m1_data_in, mem_enable);
        end
        m0_req = 0;
        tick();
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL read_after: outputs %h, required 0", outs());
        end
    endtask

    task automatic test_priority_switch();
        do_reset();
        m0_req = 1; m0_addr = 16'h8030; m0_write_en = 0;
        m1_req = 1; m1_addr = 16'h8020; m1_write_en = 1; m1_data_out = 16'hBEEF;
        tick();
        checks++;
        if ({mem_enable, mem_write_en, mem_addr} !== {2'b10, 16'h8030}) begin
            errors++;
            $display("FAIL prio_first: en/we/addr %b %b %h, required 1 0 8030",
                     mem_enable, mem_write_en, mem_addr);
        end
        tick();
        checks++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            errors++;
            $display("FAIL prio_ack0: acks %b, required 10", {m0_ack, m1_ack});
        end
        m0_req = 0;
        tick();
        checks++;
        if ({mem_enable, mem_write_en, mem_addr, mem_data_out, m0_ack} !==
            {2'b11, 16'h8020, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL switch_write: en/we/addr/data %b %b %h %h, required 1 1 8020 beef",
                     mem_enable, mem_write_en, mem_addr, mem_data_out);
        end
        tick();
        checks++;
        if (m1_ack !== 1'b1 || m1_data_in !== 16'h20DF || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL switch_ack1: m1_ack %b data %h, required 1 20df",
                     m1_ack, m1_data_in);
        end
        m1_req = 0;
        tick();
        checks++;
        if (tb_mem[8'h20] !== 16'hBEEF) begin
            errors++;
            $display("FAIL switch_mem: mem[20] %h, required beef", tb_mem[8'h20]);
        end
    endtask

    task automatic test_guard_seq();
        bit got [$];
        bit exp [10];
        int budget;
        for (int i = 0; i < 10; i++) begin
`ifdef REFLET_ARB_STARVATION_GUARD_EN
            exp[i] = (i == 4 || i == 9);
`else
            exp[i] = 1'b0;
`endif
        end
        do_reset();
        m0_req = 1; m0_addr = 16'h8001;
        m1_req = 1; m1_addr = 16'h8002;
        budget = 0;
        while (got.size() < 10 && budget < 100) begin
            tick();
            budget++;
            if (mem_enable === 1'b1) got.push_back(mem_addr == 16'h8002);
        end
        checks++;
        if (got.size() != 10) begin
            errors++;
            $display("FAIL guard_budget: grants %0d, required 10", got.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL guard_seq[%0d]: master %0d, required %0d", i, got[i], exp[i]);
                end
            end
        end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_req = 1; m1_addr = 16'h8040; m1_data_out = 16'h5555; m1_write_en = 1;
        tick();
        checks++;
        if ({mem_enable, mem_write_en} !== 2'b11) begin
            errors++;
            $display("FAIL rmid_issue: en/we %b %b, required 1 1", mem_enable, mem_write_en);
        end
        reset = 1; m1_req = 0;
        tick();
        checks++;
        if ({m1_ack, mem_write_en, mem_enable} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_abort: ack/we/en %b%b%b, required 000",
                     m1_ack, mem_write_en, mem_enable);
        end
        reset = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== '0) begin
                errors++;
                $display("FAIL rmid_idle: outputs %h, required 0", outs());
            end
        end
    endtask

    task automatic test_drop_issue();
        do_reset();
        m1_req = 1; m1_addr = 16'h8050; m1_write_en = 0;
        tick();
        checks++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h8050}) begin
            errors++;
            $display("FAIL drop_issue: en/addr %b %h, required 1 8050", mem_enable, mem_addr);
        end
        m1_req = 0;
        tick();
        checks++;
        if (m1_ack !== 1'b1 || m1_data_in !== 16'h50AF) begin
            errors++;
            $display("FAIL drop_ack: ack %b data %h, required 1 50af", m1_ack, m1_data_in);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs() !== '0) begin
                errors++;
                $display("FAIL drop_idle: outputs %h, required 0", outs());
            end
        end
    endtask

    // Model: a grant yields the memory access next cycle and the ack the cycle after.
    // A new grant is possible in any cycle without an access; the acked master may not win.
    task automatic test_random();
        bit iv, iw, im, av, am, niv, nav, nam, act0, act1;
        logic [15:0] ia, id, ad, nad;
        int mc, win;
        logic r0, r1;
        logic [67:0] exp_v;
        for (int i = 0; i < 256; i++) mdl_mem[i] = pat(8'(i));
        reset = 1; clear_inputs(); mem_init = 1;
        tick();
        mem_init = 0; reset = 0;
        iv = 0; iw = 0; im = 0; av = 0; am = 0; ia = '0; id = '0; ad = '0;
        mc = 0; act0 = 0; act1 = 0;
        for (int c = 0; c < 600; c++) begin
            r0 = m0_req; r1 = m1_req;
            nav = iv; nam = im; nad = mdl_mem[ia[7:0]];
            if (iv && iw) mdl_mem[ia[7:0]] = id;
            win = -1;
            if (!iv) begin
`ifdef REFLET_ARB_STARVATION_GUARD_EN
                if (r1 && mc >= BURST) win = 1;
                else if (r0) win = 0;
                else if (r1) win = 1;
`else
                if (r0) win = 0;
                else if (r1) win = 1;
`endif
                if (av && win == int'(am)) win = -1;
            end
            niv = (win >= 0);
            if (win == 0) begin
                ia = m0_addr; id = m0_data_out; iw = m0_write_en;
                mc = r1 ? mc + 1 : 0;
            end else if (win == 1) begin
                ia = m1_addr; id = m1_data_out; iw = m1_write_en;
                mc = 0;
            end
            im = (win == 1);
            iv = niv; av = nav; am = nam; ad = nad;
            tick();
            exp_v = {iv, iv & iw, iv ? ia : 16'h0, iv ? id : 16'h0,
                     av & !am, av & am, (av & !am) ? ad : 16'h0, (av & am) ? ad : 16'h0};
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL random cycle %0d: outputs %h, required %h", c, outs(), exp_v);
            end
            if (act0 && m0_ack) begin
                act0 = 0; m0_req = 0;
            end else if (act0 && $urandom_range(39) == 0) begin
                act0 = 0; m0_req = 0;
            end else if (!act0 && $urandom_range(2) == 0) begin
                act0 = 1; m0_req = 1;
                m0_addr = {8'h80, 8'($urandom)};
                m0_data_out = 16'($urandom);
                m0_write_en = 1'($urandom);
            end
            if (act1 && m1_ack) begin
                act1 = 0; m1_req = 0;
            end else if (act1 && $urandom_range(39) == 0) begin
                act1 = 0; m1_req = 0;
            end else if (!act1 && $urandom_range(1) == 0) begin
                act1 = 1; m1_req = 1;
                m1_addr = {8'h80, 8'($urandom)};
                m1_data_out = 16'($urandom);
                m1_write_en = 1'($urandom);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_priority_switch();
        test_guard_seq();
        test_reset_mid();
        test_drop_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
